// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//
// Shares one APB master port between two requesters (requester 0 = UART test
// engine, requester 1 = I2C test engine). An idle-state arbiter picks a winner
// (round robin on ties), then the FSM runs the APB SETUP/ACCESS handshake.
// Read data and error status go back to the winner with a one-cycle done pulse.
// A hung slave is cut off after TIMEOUT ACCESS cycles without pready.
//
// Parameters:
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  max ACCESS cycles waiting for pready (1..65535)
//
// Ports:
//   sys_clk, sys_rst_n          clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata requester N transfer request, held until done
//   reqN_rdata/done/err         requester N completion (valid while done high)
//   psel, penable, pwrite,
//   paddr, pwdata               APB master outputs (all registered)
//   prdata, pready, pslverr     APB slave responses
//   grant_id                    current or most recent owner
//   busy                        high in SETUP, ACCESS and DONE

module apb_master_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              grant_id,
  output logic              busy
);

  // Compare against TIMEOUT-1 so the abort lands on the TIMEOUT-th stalled
  // ACCESS cycle, i.e. when the count would reach TIMEOUT.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_lastGrant;
  logic                r_owner;
  logic                r_busy;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [15:0]         r_count;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_done0;
  logic                r_done1;
  logic                r_err0;
  logic                r_err1;

  logic                w_anyReq;
  logic                w_winner;
  logic                w_timeout;
  logic                w_finish;
  logic [DATA_W-1:0]   w_finalData;
  logic                w_finalErr;

  // Arbitration: a lone requester wins outright; on a tie the requester that
  // did not win last time gets the bus.
  assign w_anyReq = req0_valid | req1_valid;
  assign w_winner = (req0_valid & req1_valid) ? ~r_lastGrant : req1_valid;

  // Completion of an ACCESS: pready takes priority over the timeout, so a
  // slave answering on the very last allowed cycle still completes normally.
  // Writes and aborted transfers return zero data; pslverr only counts when
  // pready is high.
  assign w_timeout   = ~pready & (r_count == TIMEOUT_LAST);
  assign w_finish    = (r_state == ACCESS) & (pready | w_timeout);
  assign w_finalData = (pready & ~r_pwrite) ? prdata : '0;
  assign w_finalErr  = pready ? pslverr : 1'b1;

  // Main FSM with all outputs registered. Done pulses default low each cycle
  // and are raised only on the edge that enters DONE.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_busy      <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_count     <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner  <= w_winner;
            r_pwrite <= w_winner ? req1_write : req0_write;
            r_paddr  <= w_winner ? req1_addr  : req0_addr;
            r_pwdata <= w_winner ? req1_wdata : req0_wdata;
            r_psel   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_count   <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_finish) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= DONE;
            if (r_owner) begin
              r_rdata1 <= w_finalData;
              r_err1   <= w_finalErr;
              r_done1  <= 1'b1;
            end else begin
              r_rdata0 <= w_finalData;
              r_err0   <= w_finalErr;
              r_done0  <= 1'b1;
            end
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        DONE: begin
          r_lastGrant <= r_owner;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req0_rdata = r_rdata0;
  assign req0_done  = r_done0;
  assign req0_err   = r_err0;
  assign req1_rdata = r_rdata1;
  assign req1_done  = r_done1;
  assign req1_err   = r_err1;
  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign grant_id   = r_owner;
  assign busy       = r_busy;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
//
// Self-checking bench for apb_master_arbiter (TIMEOUT = 8). Single transfers
// come from a table of hand-computed vectors; round robin, reset during
// ACCESS and tie-break after reset are hand-written sequences.

module tb_apb_master_arbiter;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              req0_valid, req0_write, req0_done, req0_err;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_write, req1_done, req1_err;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic              psel, penable, pwrite, pready, pslverr, grant_id, busy;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  apb_master_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req0_valid(req0_valid),
    .req0_write(req0_write),
    .req0_addr (req0_addr),
    .req0_wdata(req0_wdata),
    .req0_rdata(req0_rdata),
    .req0_done (req0_done),
    .req0_err  (req0_err),
    .req1_valid(req1_valid),
    .req1_write(req1_write),
    .req1_addr (req1_addr),
    .req1_wdata(req1_wdata),
    .req1_rdata(req1_rdata),
    .req1_done (req1_done),
    .req1_err  (req1_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // One transfer vector. Cycle numbers count the cycle the request is first
  // presented as cycle 1. waits larger than TIMEOUT models a hung slave.
  typedef struct {
    logic        reqId;
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] slvData;
    logic        slvErr;
    logic [31:0] expRdata;
    logic        expErr;
    int          expPselCycles;
    int          expPenCycles;
    int          expDoneCycle;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic reqId, input logic write,
                               input logic [11:0] addr, input logic [31:0] wdata);
    if (reqId) begin
      req1_valid = 1'b1; req1_write = write; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_write = write; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  task automatic idleInputs();
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    prdata = '0; pready = 0; pslverr = 0;
  endtask

  task automatic resetDut();
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Runs one table vector from a negedge in IDLE. The slave model raises
  // pready after v.waits ACCESS cycles and drives pslverr high during wait
  // cycles so that a design sampling it too early is caught. Requester fields
  // are scrambled after grant to show they were latched.
  task automatic runVector(input vec_t v, input int idx);
    int   cycle, pselCnt, penCnt, accessCnt, busMismatch, otherDone;
    bit   seenDone;
    logic ownDone, othDone;
    string tag;
    tag = $sformatf("vec%0d", idx);
    cycle = 1; pselCnt = 0; penCnt = 0; accessCnt = 0;
    busMismatch = 0; otherDone = 0; seenDone = 0;
    prdata = v.slvData; pready = 0; pslverr = 0;
    applyStimulus(v.reqId, v.write, v.addr, v.wdata);
    for (int k = 0; k < 40; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      cycle++;
      if (cycle == 2) begin
        if (v.reqId) begin
          req1_addr = ~v.addr; req1_wdata = ~v.wdata; req1_write = ~v.write;
        end else begin
          req0_addr = ~v.addr; req0_wdata = ~v.wdata; req0_write = ~v.write;
        end
      end
      ownDone = v.reqId ? req1_done : req0_done;
      othDone = v.reqId ? req0_done : req1_done;
      if (othDone) otherDone++;
      if (psel) begin
        pselCnt++;
        if (paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata) busMismatch++;
      end
      if (penable) penCnt++;
      if (ownDone) begin
        seenDone = 1;
        checkOutput({tag, " doneCycle"}, 64'(cycle), 64'(v.expDoneCycle));
        checkOutput({tag, " rdata"}, v.reqId ? req1_rdata : req0_rdata, v.expRdata);
        checkOutput({tag, " err"}, v.reqId ? req1_err : req0_err, v.expErr);
        checkOutput({tag, " grant_id"}, grant_id, v.reqId);
        checkOutput({tag, " pselAtDone"}, psel, 0);
        checkOutput({tag, " busyAtDone"}, busy, 1);
        break;
      end
      if (psel && penable) begin
        accessCnt++;
        pready  = (accessCnt > v.waits);
        pslverr = pready ? v.slvErr : 1'b1;
      end else begin
        pready  = 0;
        pslverr = 0;
      end
    end
    checkOutput({tag, " doneSeen"}, seenDone, 1);
    checkOutput({tag, " pselCycles"}, 64'(pselCnt), 64'(v.expPselCycles));
    checkOutput({tag, " penableCycles"}, 64'(penCnt), 64'(v.expPenCycles));
    checkOutput({tag, " busStable"}, 64'(busMismatch), 0);
    checkOutput({tag, " otherDone"}, 64'(otherDone), 0);
    if (v.reqId) req1_valid = 0; else req0_valid = 0;
    pready = 0; pslverr = 0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput({tag, " donePulseWidth"}, v.reqId ? req1_done : req0_done, 0);
    checkOutput({tag, " busyAfter"}, busy, 0);
  endtask

  initial begin
    int   cycle, nDone, bothCnt, doneAfterRst;
    int   order[4];
    int   doneCyc[4];
    bit   seen;
    vec_t v;

    // reqId write addr wdata waits slvData slvErr expRdata expErr psel pen doneCycle
    vecs[0] = '{1'b0, 1'b1, 12'h004, 32'h000000A5,   0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 2, 1,  4};
    vecs[1] = '{1'b1, 1'b0, 12'h010, 32'h00000000,   3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 5, 4,  7};
    vecs[2] = '{1'b0, 1'b0, 12'h020, 32'h11111111,   1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 3, 2,  5};
    vecs[3] = '{1'b1, 1'b1, 12'h3FC, 32'h12345678,   2, 32'h5555AAAA, 1'b1, 32'h00000000, 1'b1, 4, 3,  6};
    vecs[4] = '{1'b0, 1'b0, 12'hABC, 32'h00000000, 100, 32'h87654321, 1'b0, 32'h00000000, 1'b1, 9, 8, 11};
    vecs[5] = '{1'b1, 1'b0, 12'hFFF, 32'h00000000,   7, 32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 1'b0, 9, 8, 11};

    idleInputs();
    resetDut();

    // Everything the design drives is zero straight out of reset.
    checkOutput("reset psel", psel, 0);
    checkOutput("reset penable", penable, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset grant_id", grant_id, 0);
    checkOutput("reset dones", {req0_done, req1_done}, 0);
    checkOutput("reset errs", {req0_err, req1_err}, 0);
    checkOutput("reset rdata", {req0_rdata, req1_rdata}, 0);
    checkOutput("reset bus", {pwrite, paddr, pwdata}, 0);

    for (int i = 0; i < 6; i++) runVector(vecs[i], i);

    // Both requesters held for four transfers: strict alternation starting
    // with requester 0, one transfer every 4 cycles.
    resetDut();
    applyStimulus(1'b0, 1'b1, 12'h100, 32'hA0A0A0A0);
    applyStimulus(1'b1, 1'b0, 12'h200, 32'h0);
    prdata = 32'h600D600D; pready = 1; pslverr = 0;
    cycle = 1; nDone = 0; bothCnt = 0;
    for (int k = 0; k < 60 && nDone < 4; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      cycle++;
      if (req0_done && req1_done) bothCnt++;
      if (req0_done || req1_done) begin
        order[nDone]   = req1_done ? 1 : 0;
        doneCyc[nDone] = cycle;
        nDone++;
        if (nDone == 4) begin
          req0_valid = 0;
          req1_valid = 0;
        end
      end
    end
    checkOutput("rr doneCount", 64'(nDone), 4);
    checkOutput("rr bothDone", 64'(bothCnt), 0);
    for (int i = 0; i < nDone; i++) begin
      checkOutput($sformatf("rr order%0d", i), 64'(order[i]), 64'(i % 2));
      checkOutput($sformatf("rr cycle%0d", i), 64'(doneCyc[i]), 64'(4 + 4 * i));
    end
    pready = 0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("rr busyAfter", busy, 0);

    // Let requester 0 win a transfer so last_grant is 0, then reset during
    // requester 1's stalled ACCESS.
    v = '{1'b0, 1'b0, 12'h044, 32'h0, 0, 32'h13579BDF, 1'b0, 32'h13579BDF, 1'b0, 2, 1, 4};
    runVector(v, 6);
    applyStimulus(1'b1, 1'b0, 12'h055, 32'h0);
    pready = 0; pslverr = 0;
    repeat (3) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    checkOutput("rst inAccess", {psel, penable}, 2'b11);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("rst psel", psel, 0);
    checkOutput("rst penable", penable, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", {req0_done, req1_done}, 0);
    sys_rst_n = 1'b1;
    req1_valid = 0;
    doneAfterRst = 0;
    repeat (4) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (req0_done || req1_done) doneAfterRst++;
    end
    checkOutput("rst noDonePulse", 64'(doneAfterRst), 0);

    // After reset the tie goes to requester 0 again.
    applyStimulus(1'b0, 1'b0, 12'h066, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h077, 32'h0);
    pready = 1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (req0_done || req1_done) begin
        seen = 1;
        checkOutput("rst tieWinner", {req1_done, req0_done}, 2'b01);
        checkOutput("rst tieGrant", grant_id, 0);
        break;
      end
    end
    checkOutput("rst tieDoneSeen", seen, 1);
    req0_valid = 0;
    req1_valid = 0;
    pready = 0;
    repeat (8) @(posedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
